// File: rtl/cic_capture_sched_if.sv
// Stream bundle for the CIC capture scheduler: per-channel strobes and
// samples in, one ready/valid serialised sample stream out.
interface cic_capture_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int TSW = 16
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic [TSW-1:0]    out_ts;

  // Scheduler side: consumes channel strobes, sources the output stream.
  modport master (
    input  ch_valid, ch_data, out_ready,
    output out_valid, out_data, out_ch, out_ts
  );

  // Environment side: drives channel strobes, sinks the output stream.
  modport slave (
    output ch_valid, ch_data, out_ready,
    input  out_valid, out_data, out_ch, out_ts
  );
endinterface

// File: rtl/cic_capture_sched.sv
// Round-robin capture scheduler: latches one-cycle CIC channel strobes with a
// timestamp into per-channel holding slots, then grants pending slots fairly
// into a single registered ready/valid output. Lost samples are flagged
// per channel in a sticky overrun vector.
module cic_capture_sched #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int TSW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NCH-1:0]          overrun_clr,
  output logic [NCH-1:0]          overrun,
  output logic [31:0]             sample_cnt,
  cic_capture_sched_if.master     bus
);
  localparam int CW = $clog2(NCH);

  // Registered state and next-state values
  logic [TSW-1:0] ts_q, ts_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [DW-1:0]  slot_data_q [NCH];
  logic [DW-1:0]  slot_data_d [NCH];
  logic [TSW-1:0] slot_ts_q [NCH];
  logic [TSW-1:0] slot_ts_d [NCH];
  logic [CW-1:0]  ptr_q, ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic [TSW-1:0] out_ts_q, out_ts_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  logic [31:0]    sample_cnt_q, sample_cnt_d;

  // Combinational helpers
  logic           load_s;
  logic           xfer_s;
  logic [NCH-1:0] strobe_s;
  logic           grant_vld_s;
  logic [CW-1:0]  grant_idx_s;
  logic [NCH-1:0] grant_oh_s;
  logic [CW:0]    scan_idx_s;

  // The output register may take a new sample when empty or being drained.
  assign load_s   = !out_valid_q || bus.out_ready;
  assign xfer_s   = out_valid_q && bus.out_ready;
  // enable only gates new captures; draining continues regardless.
  assign strobe_s = bus.ch_valid & {NCH{enable}};

  // Free-running timestamp, frozen while capture is disabled.
  always_comb begin
    ts_d = ts_q;
    if (enable) begin
      ts_d = ts_q + TSW'(1);
    end else begin
      ts_d = ts_q;
    end
  end

  // Round-robin scan of registered pend starting at ptr; first hit wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {CW{1'b0}};
    scan_idx_s  = {(CW+1){1'b0}};
    for (int i = 0; i < NCH; i++) begin
      scan_idx_s = {1'b0, ptr_q} + (CW+1)'(i);
      if (scan_idx_s >= (CW+1)'(NCH)) begin
        scan_idx_s = scan_idx_s - (CW+1)'(NCH);
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!grant_vld_s && pend_q[scan_idx_s[CW-1:0]]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = scan_idx_s[CW-1:0];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (!load_s) begin
      grant_vld_s = 1'b0;
    end else begin
      grant_vld_s = grant_vld_s;
    end
  end

  // One-hot form of the grant, used by the per-slot update logic.
  always_comb begin
    grant_oh_s = {NCH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (grant_vld_s && (grant_idx_s == CW'(k))) begin
        grant_oh_s[k] = 1'b1;
      end else begin
        grant_oh_s[k] = 1'b0;
      end
    end
  end

  // Slot capture, drop detection and pend bookkeeping per channel.
  // A slot granted this cycle is free to take a new sample in the same cycle.
  always_comb begin
    pend_d      = pend_q;
    slot_data_d = slot_data_q;
    slot_ts_d   = slot_ts_q;
    overrun_d   = overrun_q & ~overrun_clr;
    for (int k = 0; k < NCH; k++) begin
      if (strobe_s[k] && (!pend_q[k] || grant_oh_s[k])) begin
        pend_d[k]      = 1'b1;
        slot_data_d[k] = bus.ch_data[k*DW +: DW];
        slot_ts_d[k]   = ts_q;
      end else if (strobe_s[k]) begin
        // Slot still occupied and not draining: keep the old sample.
        overrun_d[k] = 1'b1;
      end else if (grant_oh_s[k]) begin
        pend_d[k] = 1'b0;
      end else begin
        pend_d[k] = pend_q[k];
      end
    end
  end

  // Output register load, round-robin pointer advance and transfer counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_ts_d     = out_ts_q;
    ptr_d        = ptr_q;
    sample_cnt_d = sample_cnt_q;
    if (grant_vld_s) begin
      out_valid_d = 1'b1;
      out_data_d  = slot_data_q[grant_idx_s];
      out_ch_d    = grant_idx_s;
      out_ts_d    = slot_ts_q[grant_idx_s];
      if (grant_idx_s == CW'(NCH - 1)) begin
        ptr_d = {CW{1'b0}};
      end else begin
        ptr_d = grant_idx_s + CW'(1);
      end
    end else if (load_s) begin
      // Nothing to grant: the register empties after its transfer.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s) begin
      sample_cnt_d = sample_cnt_q + 32'd1;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= {TSW{1'b0}};
      pend_q       <= {NCH{1'b0}};
      ptr_q        <= {CW{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {DW{1'b0}};
      out_ch_q     <= {CW{1'b0}};
      out_ts_q     <= {TSW{1'b0}};
      overrun_q    <= {NCH{1'b0}};
      sample_cnt_q <= 32'd0;
      for (int k = 0; k < NCH; k++) begin
        slot_data_q[k] <= {DW{1'b0}};
        slot_ts_q[k]   <= {TSW{1'b0}};
      end
    end else begin
      ts_q         <= ts_d;
      pend_q       <= pend_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_ts_q     <= out_ts_d;
      overrun_q    <= overrun_d;
      sample_cnt_q <= sample_cnt_d;
      for (int k = 0; k < NCH; k++) begin
        slot_data_q[k] <= slot_data_d[k];
        slot_ts_q[k]   <= slot_ts_d[k];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_ts    = out_ts_q;
  assign overrun       = overrun_q;
  assign sample_cnt    = sample_cnt_q;
endmodule
